// File: rtl/ar_modify_unit.sv
// ar_modify_unit -- auxiliary register address/modify unit.
//
// Decodes one instruction per cycle against the currently selected auxiliary
// register (AR0/AR1 chosen by arp). It produces a registered write-back to the
// AR file, a registered data-memory address and a registered BANZ branch
// condition. All outputs appear one cycle after the instruction.
//
// The value the unit works on is the selected AR. If last cycle's registered
// write targets that AR, its data is forwarded, because the external AR file
// has not caught up yet. This lets back-to-back instructions run without a
// stall.
//
// Optional build macro:
//   AR_WRAP9_EN  -- increment, decrement and BANZ act on bits [8:0] only and
//                   wrap modulo 512. Bits [W-1:9] pass through unchanged.
//                   When the macro is undefined, the arithmetic uses all W bits.
module ar_modify_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  input  logic [2:0]   op,
  input  logic [1:0]   mod,
  input  logic         nxt_arp_en,
  input  logic         nxt_arp,
  input  logic [7:0]   imm,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] ar_sel_val,
  output logic         arp,
  output logic         ar_wr_en,
  output logic         ar_wr_sel,
  output logic [W-1:0] ar_wr_data,
  output logic [7:0]   dm_addr,
  output logic         dm_addr_valid,
  output logic         banz_taken
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_IND  = 3'd1,
    OP_LARK = 3'd2,
    OP_LAR  = 3'd3,
    OP_MAR  = 3'd4,
    OP_BANZ = 3'd5
  } op_e;

  localparam logic [1:0] MOD_INC = 2'b01;
  localparam logic [1:0] MOD_DEC = 2'b10;

  // Bits that take part in inc/dec/BANZ arithmetic. Bits outside the mask pass through.
`ifdef AR_WRAP9_EN
  localparam logic [W-1:0] ARITH_MASK = W'(9'h1FF);
`else
  localparam logic [W-1:0] ARITH_MASK = '1;
`endif

  // Add +1 or -1 inside the arithmetic field and keep every bit outside it.
  function automatic logic [W-1:0] step(input logic [W-1:0] val, input logic dec);
    logic [W-1:0] full;
    full = dec ? (val - W'(1)) : (val + W'(1));
    return (val & ~ARITH_MASK) | (full & ARITH_MASK);
  endfunction

  logic         arp_q, arp_d;
  logic         wr_en_q, wr_en_d;
  logic         wr_sel_q, wr_sel_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic [7:0]   dm_addr_q, dm_addr_d;
  logic         dm_valid_q, dm_valid_d;
  logic         banz_q, banz_d;

  logic [W-1:0] eff_val;
  logic         is_instr;

  // Effective operand with forwarding, then decode and compute next-cycle outputs.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path through the case can infer a latch.
    arp_d      = arp_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = arp_q;
    wr_data_d  = '0;
    dm_addr_d  = '0;
    dm_valid_d = 1'b0;
    banz_d     = 1'b0;

    // The comparison uses arp_q, which is already the post-update pointer. A write
    // to the other AR (after an arp switch) is therefore not forwarded.
    eff_val  = (wr_en_q && (wr_sel_q == arp_q)) ? wr_data_q : ar_sel_val;
    is_instr = 1'b0;

    if (instr_valid) begin
      case (op)
        OP_IND: begin
          is_instr   = 1'b1;
          dm_addr_d  = eff_val[7:0];
          dm_valid_d = 1'b1;
          if (mod == MOD_INC || mod == MOD_DEC) begin
            wr_en_d   = 1'b1;
            wr_data_d = step(eff_val, mod == MOD_DEC);
          end
        end
        OP_LARK: begin
          is_instr  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = W'(imm);
        end
        OP_LAR: begin
          is_instr  = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = data_in;
        end
        OP_MAR: begin
          is_instr = 1'b1;
          if (mod == MOD_INC || mod == MOD_DEC) begin
            wr_en_d   = 1'b1;
            wr_data_d = step(eff_val, mod == MOD_DEC);
          end
        end
        OP_BANZ: begin
          is_instr  = 1'b1;
          banz_d    = |(eff_val & ARITH_MASK);
          wr_en_d   = 1'b1;
          wr_data_d = step(eff_val, 1'b1);
        end
        default: is_instr = 1'b0;
      endcase
    end

    // The write target above was latched from the pre-update arp. Only the
    // pointer register itself moves here.
    if (is_instr && nxt_arp_en) begin
      arp_d = nxt_arp;
    end
  end

  // Output and pointer registers. Reset clears them, which also drops a pending write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (reset) begin
      arp_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_data_q  <= '0;
      dm_addr_q  <= '0;
      dm_valid_q <= 1'b0;
      banz_q     <= 1'b0;
    end else begin
      arp_q      <= arp_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_data_q  <= wr_data_d;
      dm_addr_q  <= dm_addr_d;
      dm_valid_q <= dm_valid_d;
      banz_q     <= banz_d;
    end
  end

  assign arp           = arp_q;
  assign ar_wr_en      = wr_en_q;
  assign ar_wr_sel     = wr_sel_q;
  assign ar_wr_data    = wr_data_q;
  assign dm_addr       = dm_addr_q;
  assign dm_addr_valid = dm_valid_q;
  assign banz_taken    = banz_q;

endmodule

// File: tb/tb_ar_modify_unit.sv
// Directed bench for ar_modify_unit (W=16). Expected values are hand-computed.
// Arithmetic expectations follow AR_WRAP9_EN when the macro is defined.
module tb_ar_modify_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic [2:0]   op;
  logic [1:0]   mod;
  logic         nxt_arp_en;
  logic         nxt_arp;
  logic [7:0]   imm;
  logic [W-1:0] data_in;
  logic [W-1:0] ar_sel_val;
  logic         arp;
  logic         ar_wr_en;
  logic         ar_wr_sel;
  logic [W-1:0] ar_wr_data;
  logic [7:0]   dm_addr;
  logic         dm_addr_valid;
  logic         banz_taken;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] NOP = 3'd0, IND = 3'd1, LARK = 3'd2, LAR = 3'd3, MAR = 3'd4, BANZ = 3'd5;
  localparam logic [1:0] MN = 2'b00, MI = 2'b01, MD = 2'b10;

`ifdef AR_WRAP9_EN
  localparam logic [W-1:0] EXP_BANZ0 = 16'h01FF;
  localparam logic [W-1:0] EXP_WRAP  = 16'h8000;
`else
  localparam logic [W-1:0] EXP_BANZ0 = 16'hFFFF;
  localparam logic [W-1:0] EXP_WRAP  = 16'h8200;
`endif

  ar_modify_unit #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .op           (op),
    .mod          (mod),
    .nxt_arp_en   (nxt_arp_en),
    .nxt_arp      (nxt_arp),
    .imm          (imm),
    .data_in      (data_in),
    .ar_sel_val   (ar_sel_val),
    .arp          (arp),
    .ar_wr_en     (ar_wr_en),
    .ar_wr_sel    (ar_wr_sel),
    .ar_wr_data   (ar_wr_data),
    .dm_addr      (dm_addr),
    .dm_addr_valid(dm_addr_valid),
    .banz_taken   (banz_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction, then sample outputs 1 ns after the next rising edge.
  task automatic issue(input logic v, input logic [2:0] o, input logic [1:0] m,
                       input logic en, input logic nx);
    instr_valid = v;
    op          = o;
    mod         = m;
    nxt_arp_en  = en;
    nxt_arp     = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic a, input logic we, input logic ws,
                            input logic [W-1:0] wd, input logic [7:0] da, input logic dv,
                            input logic bt);
    check({tag, ".arp"},   32'(arp), 32'(a));
    check({tag, ".wr_en"}, 32'(ar_wr_en), 32'(we));
    check({tag, ".wr_sel"}, 32'(ar_wr_sel), 32'(ws));
    check({tag, ".wr_data"}, 32'(ar_wr_data), 32'(wd));
    check({tag, ".dm_addr"}, 32'(dm_addr), 32'(da));
    check({tag, ".dm_valid"}, 32'(dm_addr_valid), 32'(dv));
    check({tag, ".banz"},  32'(banz_taken), 32'(bt));
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; op = NOP; mod = MN; nxt_arp_en = 1'b0; nxt_arp = 1'b0;
    imm = 8'h00; data_in = '0; ar_sel_val = '0;
    #1;

    // Reset overrides a simultaneous LARK.
    imm = 8'h7E;
    issue(1'b1, LARK, MN, 1'b1, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // LARK 0x05 on AR0.
    imm = 8'h05;
    issue(1'b1, LARK, MI, 1'b0, 1'b0);
    expect_out("lark", 1'b0, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0);

    // instr_valid=0 with a write op is a NOP.
    imm = 8'h44;
    issue(1'b0, LARK, MN, 1'b1, 1'b1);
    expect_out("idle", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    // Three back-to-back IND inc with a stale ar_sel_val.
    ar_sel_val = 16'h0010;
    issue(1'b1, IND, MI, 1'b0, 1'b0);
    expect_out("ind1", 1'b0, 1'b1, 1'b0, 16'h0011, 8'h10, 1'b1, 1'b0);
    issue(1'b1, IND, MI, 1'b0, 1'b0);
    expect_out("ind2", 1'b0, 1'b1, 1'b0, 16'h0012, 8'h11, 1'b1, 1'b0);
    issue(1'b1, IND, MI, 1'b0, 1'b0);
    expect_out("ind3", 1'b0, 1'b1, 1'b0, 16'h0013, 8'h12, 1'b1, 1'b0);

    // AR0=0x20, then IND inc switching arp to 1. The write still goes to AR0.
    imm = 8'h20;
    issue(1'b1, LARK, MN, 1'b0, 1'b0);
    expect_out("lark20", 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0);
    issue(1'b1, IND, MI, 1'b1, 1'b1);
    expect_out("ind_sw", 1'b1, 1'b1, 1'b0, 16'h0021, 8'h20, 1'b1, 1'b0);

    // Next IND reads AR1 from ar_sel_val. The AR0 write is not forwarded.
    ar_sel_val = 16'h0040;
    issue(1'b1, IND, MD, 1'b0, 1'b0);
    expect_out("ind_ar1", 1'b1, 1'b1, 1'b1, 16'h003F, 8'h40, 1'b1, 1'b0);

    // MAR inc sees the forwarded AR1 value. No memory access.
    issue(1'b1, MAR, MI, 1'b0, 1'b0);
    expect_out("mar", 1'b1, 1'b1, 1'b1, 16'h0040, 8'h00, 1'b0, 1'b0);

    // NOP and op 6 ignore nxt_arp_en.
    issue(1'b1, NOP, MI, 1'b1, 1'b0);
    expect_out("nop", 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 3'd6, MI, 1'b1, 1'b0);
    expect_out("op6", 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);

    // LAR 1 into AR1, then two BANZ. The second BANZ sees the forwarded 0.
    data_in    = 16'h0001;
    ar_sel_val = 16'h5555;
    issue(1'b1, LAR, MD, 1'b0, 1'b0);
    expect_out("lar1", 1'b1, 1'b1, 1'b1, 16'h0001, 8'h00, 1'b0, 1'b0);
    issue(1'b1, BANZ, MN, 1'b0, 1'b0);
    expect_out("banz1", 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1);
    issue(1'b1, BANZ, MN, 1'b1, 1'b0);
    expect_out("banz0", 1'b0, 1'b1, 1'b1, EXP_BANZ0, 8'h00, 1'b0, 1'b0);

    // Wrap boundary: AR0 = 0x81FF, then IND inc.
    data_in    = 16'h81FF;
    ar_sel_val = 16'h0000;
    issue(1'b1, LAR, MN, 1'b0, 1'b0);
    expect_out("lar81ff", 1'b0, 1'b1, 1'b0, 16'h81FF, 8'h00, 1'b0, 1'b0);
    issue(1'b1, IND, MI, 1'b1, 1'b1);
    expect_out("wrap", 1'b1, 1'b1, 1'b0, EXP_WRAP, 8'hFF, 1'b1, 1'b0);

    // Reset in the cycle after an IND inc drops the pending write and restores arp 0.
    ar_sel_val = 16'h0033;
    issue(1'b1, IND, MI, 1'b0, 1'b0);
    expect_out("pre_rst", 1'b1, 1'b1, 1'b1, 16'h0034, 8'h33, 1'b1, 1'b0);
    reset = 1'b1;
    issue(1'b1, IND, MI, 1'b1, 1'b1);
    expect_out("rst2", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    ar_sel_val = 16'h0077;
    issue(1'b1, IND, MN, 1'b0, 1'b0);
    expect_out("post_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h77, 1'b1, 1'b0);

    // The outputs last exactly one cycle.
    issue(1'b0, NOP, MN, 1'b0, 1'b0);
    expect_out("drain", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
